timer_cnt_ctrl: RTL



---
 rtl/timer_cnt_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/timer_cnt_ctrl.sv
// Count-enable controller: prescaled one-cycle increment pulse for the timer counter, with debug halt handshake.
// Outputs registered one edge after the sampling edge; free-running, no backpressure.
module timer_cnt_ctrl #(
    parameter int MAX_DIV = 8,
    parameter int DIV_W   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_timer_en,
    input  logic             i_div_en,
    input  logic [DIV_W-1:0] i_div_val,
    input  logic             i_debug_mode,
    input  logic             i_halt_req,
    output logic             o_cnt_en,
    output logic             o_halt_ack,
    output logic [1:0]       o_state
);

    localparam int PW = MAX_DIV + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [MAX_DIV-1:0] div_cnt;
    logic [MAX_DIV-1:0] div_cnt_nxt;
    logic [MAX_DIV-1:0] limit;
    logic               div_en_q;
    logic [DIV_W-1:0]   div_val_q;
    logic [DIV_W-1:0]   div_clamp;
    logic               halt;
    logic               cfg_chg;
    logic               tick;

    // Limit comes from the registered config copies so it is stable for the whole period.
    always_comb begin
        div_clamp = (i_div_val > DIV_W'(MAX_DIV)) ? DIV_W'(MAX_DIV) : i_div_val;
        cfg_chg   = (div_en_q != i_div_en) || (div_val_q != div_clamp);
        limit     = div_en_q ? MAX_DIV'((PW'(1) << div_val_q) - PW'(1)) : '0;
        halt      = i_debug_mode && i_halt_req;
        tick      = (state == RUN) && (div_cnt == limit) && !cfg_chg;
    end

    always_comb begin
        state_nxt   = IDLE;
        div_cnt_nxt = div_cnt;
        if (halt) begin
            state_nxt = HALTED;
        end else if (i_timer_en) begin
            state_nxt = RUN;
        end
        case (state_nxt)
            IDLE: div_cnt_nxt = '0;
            RUN: begin
                // Coming out of HALTED the frozen count is kept, so the period resumes.
                if (state == RUN) begin
                    div_cnt_nxt = (div_cnt == limit) ? '0 : div_cnt + MAX_DIV'(1);
                end
            end
            HALTED: begin
                // A tick already issued on the halting edge must not be re-issued on resume.
                if ((state == RUN) && (div_cnt == limit)) begin
                    div_cnt_nxt = '0;
                end
            end
            default: div_cnt_nxt = '0;
        endcase
        if (cfg_chg) begin
            div_cnt_nxt = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            div_en_q   <= 1'b0;
            div_val_q  <= '0;
            o_cnt_en   <= 1'b0;
            o_halt_ack <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_cnt_nxt;
            div_en_q   <= i_div_en;
            div_val_q  <= div_clamp;
            o_cnt_en   <= tick;
            o_halt_ack <= (state_nxt == HALTED);
        end
    end

    assign o_state = state;

endmodule
